// File: rtl/rfphoenix_mem_wb_stage.sv
// Memory-response writeback stage: pops the response FIFO one entry at a time,
// drops rolled-back or invalid entries, and hands survivors to the RF write port.

package rfphoenix_mem_wb_pkg;
  localparam int NTHREADS = 4;
  localparam int TID_W    = $clog2(NTHREADS);
  localparam int RES_W    = 32;

  typedef struct packed {
    logic             v;
    logic [TID_W-1:0] thread;
    logic [6:0]       tgt;
    logic [RES_W-1:0] res;
  } MemoryArg_t;
endpackage

module rfphoenix_mem_wb_stage
  import rfphoenix_mem_wb_pkg::*;
#(
  parameter int ACK_TO = 255,
  parameter int DROPW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  input  MemoryArg_t          fifo_dout,
  output logic                fifo_rd,
  input  logic [NTHREADS-1:0] rollback,
  output logic                wb_req,
  input  logic                wb_ack,
  output logic [TID_W-1:0]    wb_thread,
  output logic [6:0]          wb_tgt,
  output logic [RES_W-1:0]    wb_res,
  output logic                busy,
  output logic [DROPW-1:0]    drop_cnt,
  output logic                to_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE0 = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WB      = 3'd3;
  localparam logic [2:0] S_SETTLE1 = 3'd4;

  localparam logic [15:0] TO_LAST = 16'(ACK_TO - 1);

  logic [2:0]       r_state;
  MemoryArg_t       r_hold;
  logic [15:0]      r_tcnt;
  logic [DROPW-1:0] r_drop_cnt;
  logic             r_to_err;

  logic w_in_wb;
  logic w_rb_hit;
  logic w_discard;
  logic w_timeout;
  logic w_count_drop;

  assign w_in_wb   = (r_state == S_WB);
  assign w_rb_hit  = rollback[r_hold.thread];
  assign w_discard = ~r_hold.v | w_rb_hit;
  assign w_timeout = ~wb_ack & (r_tcnt == TO_LAST);

  // Both discarded entries and abandoned (timed-out) writes count as drops.
  assign w_count_drop = w_in_wb & (w_discard | w_timeout);

  // NOTE: wb_req is combinational so a rollback strobe masks the request in the
  // very cycle it arrives; registering it would leak one stale write to the RF.
  assign wb_req    = w_in_wb & r_hold.v & ~w_rb_hit;
  assign fifo_rd   = (r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign wb_thread = r_hold.thread;
  assign wb_tgt    = r_hold.tgt;
  assign wb_res    = r_hold.res;
  assign drop_cnt  = r_drop_cnt;
  assign to_err    = r_to_err;

  // NOTE: hold is reset (not just its valid bit) so the wb_* data outputs read
  // zero out of reset instead of exposing whatever was captured before.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_tcnt     <= '0;
      r_drop_cnt <= '0;
      r_to_err   <= 1'b0;
    end else begin
      if (w_count_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROPW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            r_state <= S_SETTLE0;
          end
        end
        S_SETTLE0: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_hold  <= fifo_dout;
          r_tcnt  <= '0;
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_discard) begin
            r_hold.v <= 1'b0;
            r_state  <= S_SETTLE1;
          end else if (wb_ack) begin
            r_state <= S_SETTLE1;
          end else if (w_timeout) begin
            r_to_err <= 1'b1;
            r_state  <= S_SETTLE1;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        S_SETTLE1: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rfphoenix_mem_wb_stage.md
# rfPhoenix_mem_wb_stage

Memory-response writeback stage sitting directly downstream of the memory response FIFO. Pops one MemoryArg_t entry at a time, discards entries invalidated by thread rollback, and presents surviving load results to the register-file writeback port with a req/ack handshake. Also provides an ack-timeout watchdog and a saturating drop counter for debug.

## Interface
- ACK_TO, 255: maximum cycles wb_req may wait for wb_ack before the entry is abandoned; 1..65535.
- DROPW, 16: width of drop counter.

- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets the block).
- fifo_empty  input  1  response FIFO empty flag.
- fifo_dout  input  MemoryArg_t  FIFO head data; registered, valid two edges after the pop that exposed it.
- fifo_rd  output  1  single-cycle pop pulse to the FIFO.
- rollback  input  NTHREADS  per-thread rollback strobe.
- wb_req  output  1  writeback request.
- wb_ack  input  1  register file accepted the write this cycle.
- wb_thread  output  $clog2(NTHREADS)  thread of held entry.
- wb_tgt  output  7  target register (0..127).
- wb_res  output  width of MemoryArg_t.res  load result.
- busy  output  1  state != IDLE.
- drop_cnt  output  DROPW  saturating count of discarded entries.
- to_err  output  1  sticky: an ack timeout occurred.

## Operation
- Holding register hold (MemoryArg_t) and wait counter tcnt (16 bits).
- States: IDLE, SETTLE0, LOAD, WB, SETTLE1.
- IDLE: if !fifo_empty -> SETTLE0; else stay.
- SETTLE0: one cycle so fifo_dout reflects the head -> LOAD.
- LOAD: hold <= fifo_dout; fifo_rd=1 (only cycle it is asserted); tcnt <= 0 -> WB.
- WB: wb_req = hold.v & ~rollback[hold.thread] (combinational, so rollback masks the request in the same cycle).
  - drop condition: hold.v==0 or rollback[hold.thread]==1 -> drop_cnt+1 (saturate at all-ones), clear hold.v -> SETTLE1.
  - else wb_ack -> SETTLE1 (write committed).
  - else tcnt==ACK_TO-1 -> to_err<=1, drop_cnt+1, -> SETTLE1.
  - else tcnt+1.
- SETTLE1: one cycle, guarantees new head is visible -> IDLE.
- wb_thread/wb_tgt/wb_res driven from hold continuously; meaningful only while wb_req=1.
- rollback of a thread other than hold.thread has no effect on this block.
- Rollback arriving in LOAD: entry still captured; dropped in first WB cycle if rollback persists there, otherwise written (FIFO side invalidation sets v=0 for entries still queued).

## Timing
- Reset (rst==0): state=IDLE, hold=0, tcnt=0, drop_cnt=0, to_err=0; hence fifo_rd=0, wb_req=0, busy=0, wb_thread/tgt/res=0. Reset mid-handshake abandons the held entry with no drop count.
- Minimum per entry: IDLE, SETTLE0, LOAD, WB (ack same cycle), SETTLE1 = 5 cycles; with continuously non-empty FIFO, fifo_rd pulses every 5 cycles.
- First wb_req rises 3 cycles after fifo_empty falls (IDLE sample, SETTLE0, LOAD, then WB).
- wb_ack ignored outside WB and when wb_req=0.
- wb_ack and rollback[hold.thread] same cycle: rollback wins, entry dropped, write must be ignored by RF since wb_req=0.
- Timeout: with wb_ack never asserted, WB lasts exactly ACK_TO cycles.
- drop_cnt saturates; never wraps.

## Test plan
- Reset: hold rst=0 three cycles with fifo_empty=0 -> all outputs 0, no fifo_rd; release -> fifo_rd pulse on 3rd cycle after release.
- Single entry {thread=1,tgt=5,v=1,res=0xDEAD}, wb_ack tied 1 -> one fifo_rd, one-cycle wb_req with wb_thread=1, wb_tgt=5, wb_res=0xDEAD, drop_cnt=0.
- Entry with v=0 -> no wb_req, drop_cnt=1, return to IDLE after 5 cycles.
- Entry thread=2 in WB, wb_ack low, rollback[2] pulse at 4th WB cycle -> wb_req drops that cycle, drop_cnt=1; rollback[0] instead -> no effect, write completes on ack.
- ACK_TO=8, wb_ack never asserted -> wb_req high exactly 8 cycles, to_err=1 sticky, drop_cnt=1; next entry processed normally.
- Four back-to-back valid entries, ack immediate -> fifo_rd pulses spaced 5 cycles, tgt order preserved, then busy=0 once fifo_empty=1.
